// File: rtl/ab_enforcer_edit_logger.sv
`default_nettype none
// ============================================================================
//  Module   : ab_enforcer_edit_logger
//  Summary  : Observes the a/b parallel enforcer output stage, detects
//             enforcement edits, keeps saturating per-policy statistics and
//             buffers edit events in a first-word-fall-through FIFO drained by
//             a valid/ready host port.
//  Options  : AB_EDITLOG_TIMESTAMP_EN - prepend a CNT_W cycle timestamp to
//             every logged event.
//  Revision : 1.0 - initial release
// ============================================================================
module ab_enforcer_edit_logger #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16,
    parameter int REF_W      = 3,
`ifdef AB_EDITLOG_TIMESTAMP_EN
    localparam int EV_W      = CNT_W + 4 + 2 * REF_W
`else
    localparam int EV_W      = 4 + 2 * REF_W
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          A_ctp_in,
    input  logic                          B_ctp_in,
    input  logic                          A_ctp_out,
    input  logic                          B_ctp_out,
    input  logic [REF_W-1:0]              policy_a_recovery_ref,
    input  logic [REF_W-1:0]              policy_b_recovery_ref,
    input  logic                          clear_stats,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [EV_W-1:0]               ev_data,
    output logic [CNT_W-1:0]              edit_count_a,
    output logic [CNT_W-1:0]              edit_count_b,
    output logic [CNT_W-1:0]              drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int                 c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]   c_DEPTH   = (c_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]   c_LVL_ONE = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE = CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;  // empty
    localparam logic [1:0] c_ST_HOLD = 2'd1;  // non-empty, head presented
    localparam logic [1:0] c_ST_FULL = 2'd2;  // level == FIFO_DEPTH

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_PTR_W:0]   r_level;
    logic [c_PTR_W:0]   w_level_nxt;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [EV_W-1:0]    r_mem [FIFO_DEPTH];
    logic [CNT_W-1:0]   r_cnt_a;
    logic [CNT_W-1:0]   r_cnt_b;
    logic [CNT_W-1:0]   r_cnt_drop;
    logic               r_overflow;

    logic               w_ref_a_act;
    logic               w_ref_b_act;
    logic               w_event;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [EV_W-1:0]    w_entry;

    assign w_ref_a_act = (policy_a_recovery_ref != '0);
    assign w_ref_b_act = (policy_b_recovery_ref != '0);
    assign w_event     = w_ref_a_act || w_ref_b_act ||
                         (A_ctp_in != A_ctp_out) || (B_ctp_in != B_ctp_out);

    // A pop frees a slot in the same edge, so a full FIFO still accepts a push
    // when the host drains the head concurrently.
    assign w_pop  = (r_state != c_ST_IDLE) && ev_ready;
    assign w_push = w_event && ((r_state != c_ST_FULL) || w_pop);
    assign w_drop = w_event && (r_state == c_ST_FULL) && !w_pop;

`ifdef AB_EDITLOG_TIMESTAMP_EN
    logic [CNT_W-1:0] r_ts;

    // Free-running cycle timestamp, restarts from 0 after reset.
    always_ff @(posedge clk) begin
        if (reset) r_ts <= '0;
        else       r_ts <= r_ts + c_CNT_ONE;
    end

    assign w_entry = {r_ts, A_ctp_in, B_ctp_in, A_ctp_out, B_ctp_out,
                      policy_a_recovery_ref, policy_b_recovery_ref};
`else
    assign w_entry = {A_ctp_in, B_ctp_in, A_ctp_out, B_ctp_out,
                      policy_a_recovery_ref, policy_b_recovery_ref};
`endif

    // Next occupancy and FIFO state derived from the push/pop decision.
    always_comb begin
        w_level_nxt = r_level;
        w_state_nxt = r_state;
        if (w_push && !w_pop)      w_level_nxt = r_level + c_LVL_ONE;
        else if (w_pop && !w_push) w_level_nxt = r_level - c_LVL_ONE;
        if (w_level_nxt == '0)          w_state_nxt = c_ST_IDLE;
        else if (w_level_nxt == c_DEPTH) w_state_nxt = c_ST_FULL;
        else                            w_state_nxt = c_ST_HOLD;
    end

    // FIFO control registers; reset discards everything buffered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_level  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    // Event storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (!reset && w_push) r_mem[r_wr_ptr] <= w_entry;
    end

    // Saturating statistics; clear_stats beats a coincident increment.
    always_ff @(posedge clk) begin
        if (reset || clear_stats) begin
            r_cnt_a    <= '0;
            r_cnt_b    <= '0;
            r_cnt_drop <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_ref_a_act && (r_cnt_a != '1))  r_cnt_a    <= r_cnt_a + c_CNT_ONE;
            if (w_ref_b_act && (r_cnt_b != '1))  r_cnt_b    <= r_cnt_b + c_CNT_ONE;
            if (w_drop && (r_cnt_drop != '1))    r_cnt_drop <= r_cnt_drop + c_CNT_ONE;
            if (w_drop)                          r_overflow <= 1'b1;
        end
    end

    assign ev_valid     = (r_state != c_ST_IDLE);
    assign ev_data      = ev_valid ? r_mem[r_rd_ptr] : '0;
    assign edit_count_a = r_cnt_a;
    assign edit_count_b = r_cnt_b;
    assign drop_count   = r_cnt_drop;
    assign fifo_level   = r_level;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ab_enforcer_edit_logger.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ab_enforcer_edit_logger
//  Summary  : Directed self-checking bench for ab_enforcer_edit_logger
//             (FIFO_DEPTH=8, CNT_W=4, REF_W=3). Timestamp fields are
//             included when AB_EDITLOG_TIMESTAMP_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ab_enforcer_edit_logger;

    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = 4;
    localparam int REF_W      = 3;
`ifdef AB_EDITLOG_TIMESTAMP_EN
    localparam int EV_W = CNT_W + 4 + 2 * REF_W;
`else
    localparam int EV_W = 4 + 2 * REF_W;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             a_in, b_in, a_out, b_out;
    logic [REF_W-1:0] ref_a, ref_b;
    logic             clear_stats;
    logic             ev_valid;
    logic             ev_ready;
    logic [EV_W-1:0]  ev_data;
    logic [CNT_W-1:0] edit_count_a, edit_count_b, drop_count;
    logic [3:0]       fifo_level;
    logic             overflow;

    int total = 0;
    int bad   = 0;
    logic [EV_W-1:0] q[$];
    logic [EV_W-1:0] exp_ev;

    ab_enforcer_edit_logger #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W),
        .REF_W      (REF_W)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .A_ctp_in              (a_in),
        .B_ctp_in              (b_in),
        .A_ctp_out             (a_out),
        .B_ctp_out             (b_out),
        .policy_a_recovery_ref (ref_a),
        .policy_b_recovery_ref (ref_b),
        .clear_stats           (clear_stats),
        .ev_valid              (ev_valid),
        .ev_ready              (ev_ready),
        .ev_data               (ev_data),
        .edit_count_a          (edit_count_a),
        .edit_count_b          (edit_count_b),
        .drop_count            (drop_count),
        .fifo_level            (fifo_level),
        .overflow              (overflow)
    );

    always #5 clk = ~clk;

`ifdef AB_EDITLOG_TIMESTAMP_EN
    // Reference cycle counter: value seen at a negedge is the current cycle's.
    logic [CNT_W-1:0] m_ts = '0;
    always @(posedge clk) m_ts <= reset ? '0 : m_ts + 4'd1;
`endif

    // Expected event word for the inputs about to be applied this cycle.
    function automatic logic [EV_W-1:0] mk(input logic ai, input logic bi,
                                           input logic ao, input logic bo,
                                           input logic [REF_W-1:0] ra,
                                           input logic [REF_W-1:0] rb);
`ifdef AB_EDITLOG_TIMESTAMP_EN
        return {m_ts, ai, bi, ao, bo, ra, rb};
`else
        return {ai, bi, ao, bo, ra, rb};
`endif
    endfunction

    task automatic drive(input logic ai, input logic bi, input logic ao,
                         input logic bo, input logic [REF_W-1:0] ra,
                         input logic [REF_W-1:0] rb);
        a_in = ai; b_in = bi; a_out = ao; b_out = bo; ref_a = ra; ref_b = rb;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    endtask

    task automatic test_reset();
        reset = 1'b1; clear_stats = 1'b0; ev_ready = 1'b0; idle();
        repeat (3) @(negedge clk);
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h want=0", ev_valid); end
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL rst_level got=%0d want=0", fifo_level); end
        total++; if (ev_data !== '0) begin bad++; $display("FAIL rst_data got=%0h want=0", ev_data); end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%0h want=0", ev_valid); end
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL idle_level got=%0d want=0", fifo_level); end
        total++; if ({edit_count_a, edit_count_b, drop_count} !== 12'd0) begin bad++; $display("FAIL idle_counts got=%0h want=0", {edit_count_a, edit_count_b, drop_count}); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL idle_overflow got=%0h want=0", overflow); end
    endtask

    task automatic test_single_edit();
        ev_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 3'd0);
        exp_ev = mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 3'd0);
        @(negedge clk);
        idle();
        total++; if (ev_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0h want=1", ev_valid); end
        total++; if (ev_data !== exp_ev) begin bad++; $display("FAIL single_data got=%0h want=%0h", ev_data, exp_ev); end
        total++; if (edit_count_a !== 4'd1) begin bad++; $display("FAIL single_cnt_a got=%0d want=1", edit_count_a); end
        total++; if (fifo_level !== 4'd1) begin bad++; $display("FAIL single_level got=%0d want=1", fifo_level); end
        @(negedge clk);
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL single_popped got=%0h want=0", ev_valid); end
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL single_level0 got=%0d want=0", fifo_level); end
    endtask

    task automatic test_fill_drop();
        ev_ready = 1'b0;
        q.delete();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, i[0], 1'b0, 1'b0, 3'd0, 3'((i % 7) + 1));
            if (i < 8) q.push_back(mk(1'b0, i[0], 1'b0, 1'b0, 3'd0, 3'((i % 7) + 1)));
            @(negedge clk);
        end
        idle();
        total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL fill_level got=%0d want=8", fifo_level); end
        total++; if (drop_count !== 4'd2) begin bad++; $display("FAIL fill_drop got=%0d want=2", drop_count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fill_overflow got=%0h want=1", overflow); end
        total++; if (edit_count_b !== 4'd10) begin bad++; $display("FAIL fill_cnt_b got=%0d want=10", edit_count_b); end
        total++; if (ev_data !== q[0]) begin bad++; $display("FAIL fill_head got=%0h want=%0h", ev_data, q[0]); end
        @(negedge clk);
        total++; if (ev_data !== q[0]) begin bad++; $display("FAIL fill_head_stable got=%0h want=%0h", ev_data, q[0]); end
    endtask

    task automatic test_full_pop();
        ev_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 3'd0);
        exp_ev = mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 3'd0);
        @(negedge clk);
        idle();
        ev_ready = 1'b0;
        void'(q.pop_front());
        q.push_back(exp_ev);
        total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL fullpop_level got=%0d want=8", fifo_level); end
        total++; if (drop_count !== 4'd2) begin bad++; $display("FAIL fullpop_drop got=%0d want=2", drop_count); end
        total++; if (ev_data !== q[0]) begin bad++; $display("FAIL fullpop_head got=%0h want=%0h", ev_data, q[0]); end
        ev_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_ev = q.pop_front();
            total++; if (ev_valid !== 1'b1 || ev_data !== exp_ev) begin bad++; $display("FAIL drain_%0d got=%0h/%0h want=1/%0h", i, ev_valid, ev_data, exp_ev); end
            @(negedge clk);
        end
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%0h want=0", ev_valid); end
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL drain_level got=%0d want=0", fifo_level); end
    endtask

    task automatic test_saturation();
        ev_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1);
            @(negedge clk);
        end
        idle();
        @(negedge clk);
        total++; if (edit_count_b !== 4'd15) begin bad++; $display("FAIL sat_cnt_b got=%0d want=15", edit_count_b); end
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL sat_level got=%0d want=0", fifo_level); end
        @(negedge clk);
        total++; if (edit_count_b !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d want=15", edit_count_b); end
        total++; if (edit_count_a !== 4'd2) begin bad++; $display("FAIL sat_cnt_a got=%0d want=2", edit_count_a); end
        ev_ready = 1'b0;
        clear_stats = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd3);
        exp_ev = mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd3);
        @(negedge clk);
        clear_stats = 1'b0;
        idle();
        total++; if (edit_count_b !== 4'd0) begin bad++; $display("FAIL clr_cnt_b got=%0d want=0", edit_count_b); end
        total++; if ({edit_count_a, drop_count} !== 8'd0) begin bad++; $display("FAIL clr_cnt_a_drop got=%0h want=0", {edit_count_a, drop_count}); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clr_overflow got=%0h want=0", overflow); end
        total++; if (fifo_level !== 4'd1) begin bad++; $display("FAIL clr_level got=%0d want=1", fifo_level); end
        total++; if (ev_data !== exp_ev) begin bad++; $display("FAIL clr_event got=%0h want=%0h", ev_data, exp_ev); end
    endtask

    task automatic test_reset_mid();
        ev_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0);
            @(negedge clk);
        end
        total++; if (fifo_level !== 4'd5) begin bad++; $display("FAIL mid_level got=%0d want=5", fifo_level); end
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 3'd0);
        @(negedge clk);
        reset = 1'b0;
        idle();
        ev_ready = 1'b1;
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0h want=0", ev_valid); end
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL mid_level0 got=%0d want=0", fifo_level); end
        total++; if (ev_data !== '0) begin bad++; $display("FAIL mid_data got=%0h want=0", ev_data); end
        total++; if (edit_count_a !== 4'd0) begin bad++; $display("FAIL mid_cnt_a got=%0d want=0", edit_count_a); end
        @(negedge clk);
        total++; if (fifo_level !== 4'd0 || ev_valid !== 1'b0) begin bad++; $display("FAIL empty_pop got=%0d/%0h want=0/0", fifo_level, ev_valid); end
        ev_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0);
        exp_ev = mk(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0);
        @(negedge clk);
        idle();
        total++; if (ev_valid !== 1'b1 || ev_data !== exp_ev) begin bad++; $display("FAIL post_rst_event got=%0h/%0h want=1/%0h", ev_valid, ev_data, exp_ev); end
        total++; if (edit_count_a !== 4'd0) begin bad++; $display("FAIL post_rst_cnt_a got=%0d want=0", edit_count_a); end
    endtask

    initial begin
        test_reset();
        test_single_edit();
        test_fill_drop();
        test_full_pop();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
